muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit MULTU/MULT/DIVU/DIV unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional abort input is compiled in with `define MULDIV_ABORT_EN.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t             r_state, w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_mb;
  logic [WIDTH-1:0]   r_a_orig, r_hi, r_lo;
  logic               r_is_div, r_neg_q, r_neg_r, r_bz, r_dz, r_busy, r_done;

  logic               w_abort, w_accept, w_sub_ok;
  logic [WIDTH-1:0]   w_amag;
  logic [WIDTH:0]     w_bmag, w_msum, w_trial;
  logic [WIDTH+1:0]   w_diff;
  logic [2*WIDTH-1:0] w_mul_acc, w_div_acc, w_prod_fix;
  logic [WIDTH-1:0]   w_q_fix, w_r_fix;

`ifdef MULDIV_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_abort) w_next = S_IDLE;
               else if (r_cnt == CW'(WIDTH-1)) w_next = S_FIXUP;
      S_FIXUP: w_next = w_abort ? S_IDLE : S_DONE;
      S_DONE:  w_next = start ? S_CALC : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_accept = (w_next == S_CALC) && (r_state != S_CALC);

  // Unsigned WIDTH-bit negation of 0x80..0 yields 2^(WIDTH-1), so |a| fits exactly.
  assign w_amag = (op[0] && a[WIDTH-1]) ? -a : a;
  assign w_bmag = {1'b0, (op[0] && b[WIDTH-1]) ? -b : b};

  assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? r_mb : '0);
  assign w_mul_acc = {w_msum, r_acc[WIDTH-1:1]};

  // Remainder lives in the upper half, dividend/quotient in the lower half.
  assign w_trial   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = {1'b0, w_trial} - {1'b0, r_mb};
  assign w_sub_ok  = ~|w_diff[WIDTH+1:WIDTH];
  assign w_div_acc = w_sub_ok ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                              : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_q_fix    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r_fix    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_CALC) || (w_next == S_FIXUP);
      r_done  <= (w_next == S_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mb     <= '0;
      r_a_orig <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_bz     <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_dz     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_acc    <= {{WIDTH{1'b0}}, w_amag};
        r_mb     <= w_bmag;
        r_a_orig <= a;
        r_is_div <= op[1];
        r_neg_q  <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg_r  <= (op == 2'b11) && a[WIDTH-1];
        r_bz     <= op[1] && (b == '0);
      end else if (r_state == S_CALC) begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= r_is_div ? w_div_acc : w_mul_acc;
      end
      if (r_state == S_FIXUP && w_next == S_DONE) begin
        if (!r_is_div) begin
          {r_hi, r_lo} <= w_prod_fix;
          r_dz         <= 1'b0;
        end else if (r_bz) begin
          r_hi <= r_a_orig;
          r_lo <= '1;
          r_dz <= 1'b1;
        end else begin
          r_hi <= w_r_fix;
          r_lo <= w_q_fix;
          r_dz <= 1'b0;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
  assign dz   = r_dz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: arithmetic reference model plus per-cycle compare and directed literal checks.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        abort_r = 1'b0;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
`ifdef MULDIV_ABORT_EN
    .abort(abort_r),
`endif
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference result {dz, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, p, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: begin u = {32'b0, x} * {32'b0, y}; return {1'b0, u}; end
      2'd1: begin p = sx * sy; return {1'b0, p[63:0]}; end
      2'd2: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        return {1'b0, x % y, x / y};
      end
      default: begin
        if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Timing model: cyc counts clock edges; accepted at edge m_T -> busy for
  // cycles m_T..m_T+32, done and new result in cycle m_T+33.
  int          cyc = 0;
  int          m_T = -1;
  logic [64:0] m_pend = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0;

  function automatic bit in_busy(input int c);
    return (m_T >= 0) && (c >= m_T) && (c <= m_T + 32);
  endfunction

  function automatic bit in_done(input int c);
    return (m_T >= 0) && (c == m_T + 33);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_T  = -1;
      m_hi = '0;
      m_lo = '0;
      m_dz = 1'b0;
    end else begin
      cyc++;
      if (in_done(cyc)) {m_dz, m_hi, m_lo} = m_pend;
      if (in_busy(cyc - 1) && abort_r) m_T = -1;
      else if (start && !in_busy(cyc - 1)) begin
        m_pend = model(op, a, b);
        m_T    = cyc;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {63'b0, busy}, {63'b0, in_busy(cyc)});
      chk("cyc_done", {63'b0, done}, {63'b0, in_done(cyc)});
      chk("cyc_hi", {32'b0, hi}, {32'b0, m_hi});
      chk("cyc_lo", {32'b0, lo}, {32'b0, m_lo});
      chk("cyc_dz", {63'b0, dz}, {63'b0, m_dz});
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int n, nb;
    start = 1'b1; op = o; a = x; b = y;
    n = 0; nb = 0;
    @(negedge clk); n++;
    start = 1'b0;
    while (!done && n < 60) begin
      if (busy) nb++;
      @(negedge clk); n++;
    end
    chk({nm, "_done"}, {63'b0, done}, 64'd1);
    chk({nm, "_lat"}, 64'(n), 64'd34);
    chk({nm, "_busycyc"}, 64'(nb), 64'd33);
    chk({nm, "_hi"}, {32'b0, hi}, {32'b0, eh});
    chk({nm, "_lo"}, {32'b0, lo}, {32'b0, el});
    chk({nm, "_dz"}, {63'b0, dz}, {63'b0, ed});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dz", {63'b0, dz}, 64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    run_op("multu_max", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    run_op("mult_neg",  2'd1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("div_neg",   2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    run_op("divu_z",    2'd2, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op("divu_7",    2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf",   2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    @(negedge clk);
    run_op("mult_min",  2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0);
    run_op("div_rs",    2'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);

    // start pulse while busy must be ignored
    start = 1'b1; op = 2'd0; a = 32'd6; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; a = 32'd1; b = 32'd1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!done && n < 60) begin @(negedge clk); n++; end
    chk("ign_done", {63'b0, done}, 64'd1);
    chk("ign_hi", {32'b0, hi}, 64'd0);
    chk("ign_lo", {32'b0, lo}, 64'd42);
    run_op("b2b_divz", 2'd3, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 1'b1);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    chk("mid_rst_hi", {32'b0, hi}, 64'd0);
    chk("mid_rst_lo", {32'b0, lo}, 64'd0);
    chk("mid_rst_dz", {63'b0, dz}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    run_op("post_rst", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

`ifdef MULDIV_ABORT_EN
    @(negedge clk);
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    abort_r = 1'b1;
    @(negedge clk); abort_r = 1'b0;
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    chk("abort_hi", {32'b0, hi}, 64'd2);
    chk("abort_lo", {32'b0, lo}, 64'd14);
    repeat (40) @(negedge clk);
    run_op("post_abort", 2'd3, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
